i2c_write_engine: RTL and testbench

//  Single-master I2C write engine that executes one 4-byte write: slave addr, sub addr, data[15:8], data[7:0].

---
 rtl/i2c_write_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_write_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_engine.sv
// i2c_write_engine: single-master, write-only I2C engine. Sends one 4-byte
// write (slave addr, sub addr, data[15:8], data[7:0]) per accepted request,
// with all bus timing derived from the system clock in quarter-SCL steps.
//
// Ports:
//   iCLK      in    system clock (only clock)
//   iRST      in    synchronous active-high reset
//   iGO       in    level request, sampled only in IDLE
//   iDATA     in    {slave_addr, sub_addr, data[15:0]}, latched on acceptance
//   oBUSY     out   high from acceptance until return to IDLE
//   oEND      out   transaction finished, held until iGO drops
//   oNACK     out   some byte was not acknowledged (valid while oEND=1)
//   I2C_SCLK  out   SCL, push-pull
//   I2C_SDAT  inout SDA, open-drain (drives 0 or releases)
module i2c_write_engine #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned I2C_FREQ = 100000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iGO,
    input  logic [31:0] iDATA,
    output logic        oBUSY,
    output logic        oEND,
    output logic        oNACK,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    localparam int unsigned QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic [QW-1:0]   r_qcnt,  w_qcnt;
    logic [1:0]      r_phase, w_phase;
    logic [2:0]      r_bit,   w_bit;
    logic [1:0]      r_byte,  w_byte;
    logic [31:0]     r_shreg, w_shreg;
    logic            r_nack,  w_nack;
    logic            r_busy,  w_busy;
    logic            r_end,   w_end;
    logic            r_scl,   w_scl;
    logic            r_sda_low, w_sda_low;

    logic            w_tick;
    logic            w_sda_in;

    // Quarter-period boundary: last cycle of the current quarter
    assign w_tick   = (r_qcnt == QW'(QDIV - 1));
    assign w_sda_in = I2C_SDAT;

    // Open-drain SDA: only ever pull low or release
    assign I2C_SDAT = r_sda_low ? 1'b0 : 1'bz;
    assign I2C_SCLK = r_scl;
    assign oBUSY    = r_busy;
    assign oEND     = r_end;
    assign oNACK    = r_nack;

    // State and datapath registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_phase   <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_shreg   <= '0;
            r_nack    <= 1'b0;
            r_busy    <= 1'b0;
            r_end     <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_qcnt    <= w_qcnt;
            r_phase   <= w_phase;
            r_bit     <= w_bit;
            r_byte    <= w_byte;
            r_shreg   <= w_shreg;
            r_nack    <= w_nack;
            r_busy    <= w_busy;
            r_end     <= w_end;
            r_scl     <= w_scl;
            r_sda_low <= w_sda_low;
        end
    end

    // Next-state logic; bus pins are computed from the next step so they
    // change on the same edge that starts each quarter
    always_comb begin
        w_state   = r_state;
        w_qcnt    = w_tick ? '0 : r_qcnt + QW'(1);
        w_phase   = r_phase;
        w_bit     = r_bit;
        w_byte    = r_byte;
        w_shreg   = r_shreg;
        w_nack    = r_nack;
        w_busy    = r_busy;
        w_end     = r_end;
        w_scl     = 1'b1;
        w_sda_low = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_qcnt = '0;
                if (iGO) begin
                    w_state = S_START;
                    w_phase = 2'd0;
                    w_bit   = 3'd0;
                    w_byte  = 2'd0;
                    w_shreg = iDATA;
                    w_nack  = 1'b0;
                    w_busy  = 1'b1;
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (r_phase == 2'd0) begin
                        w_phase = 2'd1;
                    end else begin
                        w_state = S_BITS;
                        w_phase = 2'd0;
                        w_bit   = 3'd0;
                    end
                end
            end

            S_BITS: begin
                if (w_tick) begin
                    if (r_phase == 2'd3) begin
                        w_shreg = {r_shreg[30:0], 1'b0};
                        w_phase = 2'd0;
                        if (r_bit == 3'd7) begin
                            w_state = S_ACK;
                        end else begin
                            w_bit = r_bit + 3'd1;
                        end
                    end else begin
                        w_phase = r_phase + 2'd1;
                    end
                end
            end

            S_ACK: begin
                if (w_tick) begin
                    if (r_phase == 2'd3) begin
                        w_phase = 2'd0;
                        if (r_nack || (r_byte == 2'd3)) begin
                            w_state = S_STOP;
                        end else begin
                            w_state = S_BITS;
                            w_byte  = r_byte + 2'd1;
                            w_bit   = 3'd0;
                        end
                    end else begin
                        // Entering Q3: SCL has been high a full quarter
                        if ((r_phase == 2'd2) && w_sda_in) begin
                            w_nack = 1'b1;
                        end
                        w_phase = r_phase + 2'd1;
                    end
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    if (r_phase == 2'd2) begin
                        w_state = S_DONE;
                        w_phase = 2'd0;
                        w_end   = 1'b1;
                    end else begin
                        w_phase = r_phase + 2'd1;
                    end
                end
            end

            S_DONE: begin
                w_qcnt = '0;
                if (!iGO) begin
                    w_state = S_IDLE;
                    w_end   = 1'b0;
                    w_busy  = 1'b0;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_qcnt  = '0;
            end
        endcase

        // Bus pin shape for the quarter about to start
        case (w_state)
            S_START: begin
                w_scl     = (w_phase == 2'd0);
                w_sda_low = 1'b1;
            end
            S_BITS: begin
                w_scl     = w_phase[1];
                w_sda_low = ~w_shreg[31];
            end
            S_ACK: begin
                w_scl     = w_phase[1];
            end
            S_STOP: begin
                w_scl     = (w_phase != 2'd0);
                w_sda_low = (w_phase != 2'd2);
            end
            default: begin
                w_scl     = 1'b1;
                w_sda_low = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Scoreboard bench for i2c_write_engine: stimulus pushes expected bus bytes
// and completion records; a bus monitor/slave model and a completion monitor
// pop and compare as the DUT produces them.
module tb_i2c_write_engine;

    localparam int unsigned CLK_FREQ = 800;
    localparam int unsigned I2C_FREQ = 100;

    typedef struct {
        int   lat;
        logic nack;
    } end_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [31:0] din;
    logic        busy, endf, nackf, scl;
    logic        slave_low = 1'b0;
    wire         sda;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_write_engine #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iGO      (go),
        .iDATA    (din),
        .oBUSY    (busy),
        .oEND     (endf),
        .oNACK    (nackf),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          nack_byte = 0;
    int          stray = 0;
    logic [7:0]  exp_bytes[$];
    end_t        exp_end[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor and ACKing slave model
    logic       p_scl = 1'b1, p_sda = 1'b1;
    bit         in_frame = 0, pending = 0;
    logic       pend_bit = 1'b0;
    logic [7:0] shv = '0;
    int         bitcnt = 0, byte_idx = 0;

    always @(negedge clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (rst) begin
            in_frame  = 0;
            pending   = 0;
            bitcnt    = 0;
            byte_idx  = 0;
            slave_low = 1'b0;
        end else if (p_scl && s_scl && p_sda && !s_sda) begin
            chk("start_outside_frame", 32'(in_frame), 32'd0);
            in_frame = 1;
            pending  = 0;
            bitcnt   = 0;
            byte_idx = 0;
        end else if (p_scl && s_scl && !p_sda && s_sda) begin
            if (in_frame) chk("stop_on_byte_boundary", 32'(bitcnt), 32'd0);
            in_frame = 0;
            pending  = 0;
        end else if (!p_scl && s_scl) begin
            if (in_frame) begin
                pending  = 1;
                pend_bit = s_sda;
            end else begin
                stray++;
            end
        end else if (p_scl && !s_scl && in_frame && pending) begin
            pending = 0;
            bitcnt++;
            if (bitcnt <= 8) shv = {shv[6:0], pend_bit};
            if (bitcnt == 8) begin
                byte_idx++;
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", shv);
                end else begin
                    chk("bus_byte", 32'(shv), 32'(exp_bytes.pop_front()));
                end
                slave_low = (byte_idx != nack_byte);
            end else if (bitcnt == 9) begin
                bitcnt    = 0;
                slave_low = 1'b0;
            end
        end
        p_scl = s_scl;
        p_sda = s_sda;
    end

    // Completion monitor: latency from acceptance, NACK flag, bus cleanliness
    logic p_busy = 1'b0, p_end = 1'b0;
    int   t0 = 0;

    always @(negedge clk) begin
        end_t e;
        if (rst) begin
            p_busy = 1'b0;
            p_end  = 1'b0;
        end else begin
            if (busy && !p_busy) t0 = cyc;
            if (endf && !p_end) begin
                if (exp_end.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: got oEND=1 expected none");
                end else begin
                    e = exp_end.pop_front();
                    chk("end_latency", 32'(cyc - t0), 32'(e.lat));
                    chk("end_nack", 32'(nackf), 32'(e.nack));
                    chk("bytes_all_seen", 32'(exp_bytes.size()), 32'd0);
                    chk("stray_scl", 32'(stray), 32'd0);
                end
            end
            p_busy = busy;
            p_end  = endf;
        end
    end

    task automatic push_exp(input logic [31:0] d, input int k, input int lat, input logic nk);
        end_t e;
        int   n;
        n = (k == 0) ? 4 : k;
        for (int i = 0; i < n; i++) exp_bytes.push_back(d[31-8*i -: 8]);
        e.lat = lat;
        e.nack = nk;
        exp_end.push_back(e);
        nack_byte = k;
        din = d;
    endtask

    task automatic wait_finish(input int hold);
        bit ok;
        for (int i = 0; i < 2000 && !endf; i++) @(negedge clk);
        if (!endf) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: got oEND=0 expected 1");
        end
        ok = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!endf || !busy) ok = 0;
        end
        if (hold > 0) chk("end_held_while_go", 32'(ok), 32'd1);
        go = 1'b0;
        @(negedge clk);
        chk("end_clear", 32'(endf), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic run_xfer(input logic [31:0] d, input int k, input int lat,
                            input logic nk, input int hold);
        push_exp(d, k, lat, nk);
        go = 1'b1;
        wait_finish(hold);
    endtask

    initial begin
        bit quiet;
        rst = 1'b1;
        go  = 1'b0;
        din = '0;
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda === 1'b0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_end", 32'(endf), 32'd0);
        chk("rst_nack", 32'(nackf), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // T1 full write
        run_xfer(32'hA00B8000, 0, 298, 1'b0, 0);
        // T2 address NACK
        run_xfer(32'h5A123456, 1, 82, 1'b1, 0);
        // T3 data-low NACK, T3b byte-2 NACK
        run_xfer(32'h3C55AA0F, 4, 298, 1'b1, 0);
        run_xfer(32'h81C37E18, 2, 154, 1'b1, 0);
        // T4 handshake then re-raised request
        run_xfer(32'hE1020304, 0, 298, 1'b0, 10);
        run_xfer(32'h42FF0001, 0, 298, 1'b0, 3);

        // T5 reset during byte 2
        push_exp(32'hC35AA53C, 0, 298, 1'b0);
        go = 1'b1;
        repeat (100) @(negedge clk);
        chk("bytes_before_reset", 32'(exp_bytes.size()), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_scl", 32'(scl), 32'd1);
        chk("abort_sda", 32'(sda === 1'b0), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_end", 32'(endf), 32'd0);
        chk("abort_nack", 32'(nackf), 32'd0);
        exp_bytes.delete();
        exp_end.delete();
        quiet = 1;
        repeat (5) begin
            @(negedge clk);
            if (scl !== 1'b1 || sda === 1'b0) quiet = 0;
        end
        chk("abort_no_stop", 32'(quiet), 32'd1);
        // iGO already high as reset releases
        push_exp(32'h0D0E0F10, 0, 298, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("accept_after_reset", 32'(busy), 32'd1);
        wait_finish(0);

        // T6 iDATA and iGO disturbed mid-transfer
        push_exp(32'h960FF069, 0, 298, 1'b0);
        go = 1'b1;
        repeat (40) @(negedge clk);
        din = 32'hFFFFFFFF;
        go  = 1'b0;
        repeat (3) @(negedge clk);
        go  = 1'b1;
        din = 32'h00000000;
        repeat (100) @(negedge clk);
        go  = 1'b0;
        repeat (2) @(negedge clk);
        go  = 1'b1;
        din = 32'h12345678;
        wait_finish(0);
        quiet = 1;
        repeat (20) begin
            @(negedge clk);
            if (busy) quiet = 0;
        end
        chk("no_second_xfer", 32'(quiet), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
